// File: rtl/arf_sequencer_if.sv
// Command/handshake and address-register-file control bundle for the
// ARF sequencer. The sequencer is the slave; the requester/environment
// (command source, register file and memory) is the master.
interface arf_sequencer_if;
    logic        cmdValid;
    logic [2:0]  cmd;
    logic        cmdReady;
    logic        done;
    logic [7:0]  memData;
    logic [1:0]  arfOutCSel;
    logic [1:0]  arfOutDSel;
    logic [1:0]  arfFunSel;
    logic [2:0]  arfRegSel;
    logic        iSrcSel;
    logic        memEn;
    logic        memWr;
    logic        memByteSel;
    logic [15:0] popWord;

    modport slave (
        input  cmdValid, cmd, memData,
        output cmdReady, done, arfOutCSel, arfOutDSel, arfFunSel,
               arfRegSel, iSrcSel, memEn, memWr, memByteSel, popWord
    );

    modport master (
        output cmdValid, cmd, memData,
        input  cmdReady, done, arfOutCSel, arfOutDSel, arfFunSel,
               arfRegSel, iSrcSel, memEn, memWr, memByteSel, popWord
    );
endinterface

// File: rtl/arf_sequencer.sv
// ARF sequencer: accepts one stack/PC command at a time and steps the
// address register file and memory through it with Moore-decoded controls.
// Stack grows downward; SP points at the next free byte, high byte first.
module arf_sequencer (
    input  logic           clock_i,
    input  logic           reset_i,
    arf_sequencer_if.slave bus
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_CLR  = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_JMP  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_CALL = 3'b110;
    localparam logic [2:0] OP_RET  = 3'b111;

    typedef enum logic [3:0] {
        IDLE, NOPS, CLRS, INCS, JMPS, PUSH_H, PUSH_L,
        POP_A, POP_L, POP_H, FIN, LDPC
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  opcode_q, opcode_d;
    logic [15:0] popWord_q, popWord_d;
    logic        isCall, isRet;

    assign isCall      = (opcode_q == OP_CALL);
    assign isRet       = (opcode_q == OP_RET);
    assign bus.popWord = popWord_q;

    // State, latched opcode and assembled pop word registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            opcode_q  <= OP_NOP;
            popWord_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            popWord_q <= popWord_d;
        end
    end

    // Next-state and Moore output decode; reset forces the side-effect
    // outputs low so an aborted command leaves nothing half-written.
    always_comb begin
        state_d        = state_q;
        opcode_d       = opcode_q;
        popWord_d      = popWord_q;
        bus.cmdReady   = 1'b0;
        bus.done       = 1'b0;
        bus.arfOutCSel = 2'b00;
        bus.arfOutDSel = 2'b01;
        bus.arfFunSel  = 2'b00;
        bus.arfRegSel  = 3'b000;
        bus.iSrcSel    = 1'b0;
        bus.memEn      = 1'b0;
        bus.memWr      = 1'b0;
        bus.memByteSel = 1'b0;

        case (state_q)
            IDLE: begin
                bus.cmdReady = 1'b1;
                if (bus.cmdValid) begin
                    opcode_d = bus.cmd;
                    case (bus.cmd)
                        OP_NOP:           state_d = NOPS;
                        OP_CLR:           state_d = CLRS;
                        OP_INC:           state_d = INCS;
                        OP_JMP:           state_d = JMPS;
                        OP_PUSH, OP_CALL: state_d = PUSH_H;
                        default:          state_d = POP_A;
                    endcase
                end
            end
            NOPS: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            CLRS: begin
                bus.arfRegSel = 3'b111;
                bus.arfFunSel = 2'b11;
                bus.done      = 1'b1;
                state_d       = IDLE;
            end
            INCS: begin
                bus.arfRegSel = 3'b100;
                bus.arfFunSel = 2'b01;
                bus.done      = 1'b1;
                state_d       = IDLE;
            end
            JMPS: begin
                bus.arfRegSel = 3'b100;
                bus.arfFunSel = 2'b10;
                bus.iSrcSel   = 1'b0;
                bus.done      = 1'b1;
                state_d       = IDLE;
            end
            PUSH_H, PUSH_L: begin
                bus.memEn      = 1'b1;
                bus.memWr      = 1'b1;
                bus.memByteSel = (state_q == PUSH_H);
                bus.arfOutCSel = isCall ? 2'b00 : 2'b10;
                bus.arfRegSel  = 3'b010;
                bus.arfFunSel  = 2'b00;
                if (state_q == PUSH_H) begin
                    state_d = PUSH_L;
                end else if (isCall) begin
                    state_d = JMPS;
                end else begin
                    bus.done = 1'b1;
                    state_d  = IDLE;
                end
            end
            POP_A: begin
                bus.arfRegSel = 3'b010;
                bus.arfFunSel = 2'b01;
                state_d       = POP_L;
            end
            POP_L: begin
                bus.memEn       = 1'b1;
                bus.arfRegSel   = 3'b010;
                bus.arfFunSel   = 2'b01;
                popWord_d[7:0]  = bus.memData;
                state_d         = POP_H;
            end
            POP_H: begin
                bus.memEn       = 1'b1;
                popWord_d[15:8] = bus.memData;
                state_d         = isRet ? LDPC : FIN;
            end
            FIN: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            LDPC: begin
                bus.arfRegSel = 3'b100;
                bus.arfFunSel = 2'b10;
                bus.iSrcSel   = 1'b1;
                bus.done      = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (reset_i) begin
            bus.arfRegSel = 3'b000;
            bus.memEn     = 1'b0;
            bus.memWr     = 1'b0;
            bus.done      = 1'b0;
            bus.cmdReady  = 1'b0;
        end
    end

endmodule

// File: tb/tb_arf_sequencer.sv
// Bench for arf_sequencer: models the address register file and a byte
// memory driven by the sequencer controls, and scoreboards command latency.
module tb_arf_sequencer;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_CLR  = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_JMP  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_CALL = 3'b110;
    localparam logic [2:0] OP_RET  = 3'b111;

    typedef struct {
        logic [2:0] op;
        int         latency;
    } sbEntry_t;

    logic clock;
    logic reset;
    arf_sequencer_if bus ();

    arf_sequencer dut (
        .clock_i (clock),
        .reset_i (reset),
        .bus     (bus.slave)
    );

    int assertions = 0;
    int failures   = 0;
    sbEntry_t sbQ[$];

    logic [15:0] pc, sp, ar;
    logic [15:0] jmpOperand;
    logic        loadReq;
    logic [15:0] loadPc, loadSp, loadAr;
    logic [7:0]  mem [0:65535];
    int          writeCount = 0;
    int          doneCount  = 0;
    logic [15:0] outC, outD, iBus;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register-file output muxes and combinational memory read.
    always_comb begin
        case (bus.arfOutCSel)
            2'b00:   outC = pc;
            2'b01:   outC = sp;
            default: outC = ar;
        endcase
        case (bus.arfOutDSel)
            2'b00:   outD = pc;
            2'b01:   outD = sp;
            default: outD = ar;
        endcase
        iBus = bus.iSrcSel ? bus.popWord : jmpOperand;
    end

    assign bus.memData = (bus.memEn && !bus.memWr) ? mem[outD] : 8'h00;

    function automatic logic [15:0] applyFun(input logic [1:0] f, input logic [15:0] q,
                                             input logic [15:0] i);
        case (f)
            2'b00:   return q - 16'd1;
            2'b01:   return q + 16'd1;
            2'b10:   return i;
            default: return 16'h0000;
        endcase
    endfunction

    // Register file and memory react only to the sequencer's outputs.
    always @(posedge clock) begin
        if (loadReq) begin
            pc <= loadPc;
            sp <= loadSp;
            ar <= loadAr;
        end else begin
            if (bus.arfRegSel[2]) pc <= applyFun(bus.arfFunSel, pc, iBus);
            if (bus.arfRegSel[1]) sp <= applyFun(bus.arfFunSel, sp, iBus);
            if (bus.arfRegSel[0]) ar <= applyFun(bus.arfFunSel, ar, iBus);
        end
        if (bus.memEn && bus.memWr) begin
            mem[outD]  <= bus.memByteSel ? outC[15:8] : outC[7:0];
            writeCount <= writeCount + 1;
        end
        if (bus.done) doneCount <= doneCount + 1;
    end

    function automatic int expLatency(input logic [2:0] op);
        case (op)
            OP_PUSH: return 2;
            OP_CALL: return 3;
            OP_POP:  return 4;
            OP_RET:  return 4;
            default: return 1;
        endcase
    endfunction

    task automatic presetRegs(input logic [15:0] pcV, input logic [15:0] spV,
                              input logic [15:0] arV);
        loadReq = 1'b1;
        loadPc  = pcV;
        loadSp  = spV;
        loadAr  = arV;
        @(negedge clock);
        loadReq = 1'b0;
    endtask

    // Issue one command from a negedge and follow it to its Done cycle.
    task automatic runCmd(input logic [2:0] c, input bit hold);
        int cycles;
        bit seen;
        sbEntry_t exp;
        cycles = 0;
        while (bus.cmdReady !== 1'b1 && cycles < 10) begin
            @(negedge clock);
            cycles++;
        end
        assertions++;
        if (bus.cmdReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL idle_before_cmd: cmdReady=%b required 1", bus.cmdReady);
        end
        sbQ.push_back('{op: c, latency: expLatency(c)});
        bus.cmdValid = 1'b1;
        bus.cmd      = c;
        @(negedge clock);
        if (!hold) bus.cmdValid = 1'b0;
        bus.cmd = ~c;
        cycles  = 1;
        seen    = 1'b0;
        while (!seen && cycles <= 12) begin
            assertions++;
            if (bus.cmdReady !== 1'b0) begin
                failures++;
                $display("[TB] FAIL busy_ready op=%b cycle=%0d: cmdReady=%b required 0",
                         c, cycles, bus.cmdReady);
            end
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(negedge clock);
                cycles++;
            end
        end
        bus.cmdValid = 1'b0;
        exp = sbQ.pop_front();
        assertions++;
        if (!seen || cycles != exp.latency) begin
            failures++;
            $display("[TB] FAIL latency op=%b: seen=%b cycles=%0d required %0d",
                     exp.op, seen, cycles, exp.latency);
        end
        @(negedge clock);
        assertions++;
        if (bus.cmdReady !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL after_done op=%b: cmdReady=%b done=%b required 1/0",
                     c, bus.cmdReady, bus.done);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        assertions++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.cmdValid = 1'b1;
        bus.cmd      = OP_PUSH;
        repeat (3) @(negedge clock);
        assertions++;
        if (bus.cmdReady !== 1'b0 || bus.done !== 1'b0 || bus.memEn !== 1'b0 ||
            bus.memWr !== 1'b0 || bus.arfRegSel !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_outputs: rdy=%b done=%b en=%b wr=%b sel=%b required 0",
                     bus.cmdReady, bus.done, bus.memEn, bus.memWr, bus.arfRegSel);
        end
        bus.cmdValid = 1'b0;
        reset        = 1'b0;
        #1;
        assertions++;
        if (bus.cmdReady !== 1'b1 || bus.arfOutDSel !== 2'b01) begin
            failures++;
            $display("[TB] FAIL reset_idle: cmdReady=%b outDSel=%b required 1/01",
                     bus.cmdReady, bus.arfOutDSel);
        end
        check16("reset_popword", bus.popWord, 16'h0000);
        assertions++;
        if (writeCount != 0) begin
            failures++;
            $display("[TB] FAIL reset_no_write: writes=%0d required 0", writeCount);
        end
        @(negedge clock);
    endtask

    task automatic test_push_pop();
        int w0;
        presetRegs(16'h0000, 16'h0100, 16'h1234);
        w0 = writeCount;
        runCmd(OP_PUSH, 1'b0);
        check16("push_mem_hi", {8'h00, mem[16'h0100]}, 16'h0012);
        check16("push_mem_lo", {8'h00, mem[16'h00FF]}, 16'h0034);
        check16("push_sp", sp, 16'h00FE);
        check16("push_writes", 16'(writeCount - w0), 16'd2);
        w0 = writeCount;
        runCmd(OP_POP, 1'b0);
        check16("pop_word", bus.popWord, 16'h1234);
        check16("pop_sp", sp, 16'h0100);
        check16("pop_writes", 16'(writeCount - w0), 16'd0);
    endtask

    task automatic test_call_ret();
        presetRegs(16'h0020, 16'h0200, 16'h1234);
        jmpOperand = 16'h0400;
        runCmd(OP_CALL, 1'b0);
        check16("call_mem_hi", {8'h00, mem[16'h0200]}, 16'h0000);
        check16("call_mem_lo", {8'h00, mem[16'h01FF]}, 16'h0020);
        check16("call_sp", sp, 16'h01FE);
        check16("call_pc", pc, 16'h0400);
        runCmd(OP_RET, 1'b0);
        check16("ret_pc", pc, 16'h0020);
        check16("ret_sp", sp, 16'h0200);
        check16("ret_popword", bus.popWord, 16'h0020);
    endtask

    task automatic test_clr_inc();
        presetRegs(16'h1234, 16'h5555, 16'h7777);
        runCmd(OP_CLR, 1'b1);
        for (int i = 0; i < 3; i++) runCmd(OP_INC, 1'b1);
        check16("clrinc_pc", pc, 16'h0003);
        check16("clrinc_sp", sp, 16'h0000);
        check16("clrinc_ar", ar, 16'h0000);
    endtask

    task automatic test_back_to_back();
        int d0;
        jmpOperand = 16'h0ABC;
        d0 = doneCount;
        runCmd(OP_NOP, 1'b0);
        runCmd(OP_JMP, 1'b0);
        runCmd(OP_INC, 1'b0);
        check16("b2b_pc", pc, 16'h0ABD);
        check16("b2b_dones", 16'(doneCount - d0), 16'd3);
    endtask

    task automatic test_reset_mid();
        int w0, d0;
        presetRegs(16'h0000, 16'h0100, 16'hABCD);
        w0 = writeCount;
        d0 = doneCount;
        bus.cmdValid = 1'b1;
        bus.cmd      = OP_PUSH;
        @(negedge clock);
        bus.cmdValid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        assertions++;
        if (bus.memEn !== 1'b0 || bus.memWr !== 1'b0 || bus.arfRegSel !== 3'b000 ||
            bus.done !== 1'b0 || bus.cmdReady !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_gating: en=%b wr=%b sel=%b done=%b rdy=%b required 0",
                     bus.memEn, bus.memWr, bus.arfRegSel, bus.done, bus.cmdReady);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        assertions++;
        if (bus.cmdReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_ready: cmdReady=%b required 1", bus.cmdReady);
        end
        check16("midreset_sp", sp, 16'h00FF);
        check16("midreset_mem_hi", {8'h00, mem[16'h0100]}, 16'h00AB);
        check16("midreset_mem_lo", {8'h00, mem[16'h00FF]}, 16'h0034);
        check16("midreset_writes", 16'(writeCount - w0), 16'd1);
        check16("midreset_no_done", 16'(doneCount - d0), 16'd0);
        @(negedge clock);
    endtask

    initial begin
        reset        = 1'b1;
        loadReq      = 1'b0;
        loadPc       = 16'h0000;
        loadSp       = 16'h0000;
        loadAr       = 16'h0000;
        jmpOperand   = 16'h0000;
        bus.cmdValid = 1'b0;
        bus.cmd      = OP_NOP;
        @(negedge clock);
        test_reset();
        test_push_pop();
        test_call_ret();
        test_clr_inc();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
